// File: rtl/engine_forward_data_receiver_if.sv
// ---------------------------------------------------------------------------
// engine_forward_data_receiver_if
//
// Purpose: bundles the packet and handshake signals of the engine
// forward-data receiver into a single port.
//
// Signal groups:
//   req_*  : upstream EnginePacket (valid, hops, data). There is no ready:
//            a packet transfers on any cycle with req_valid=1.
//   bt_*   : registered ingress-FIFO state {full, empty, prog_full, valid}.
//            The upstream generator gates its pops on this backtrack state.
//   rsp_*  : local delivery port (hops==0). rsp_rd_en is the consumer ready.
//   fwd_*  : bypass delivery port (hops>0). fwd_rd_en is the consumer ready.
//
// Modports:
//   slave  : the receiver itself.
//   master : the environment (upstream generator plus the two consumers).
//
// HOPS_W and DATA_W must match the parameters of the receiver instance.
// ---------------------------------------------------------------------------
interface engine_forward_data_receiver_if #(
  parameter int HOPS_W = 8,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic [HOPS_W-1:0] req_hops;
  logic [DATA_W-1:0] req_data;

  logic              bt_full;
  logic              bt_empty;
  logic              bt_prog_full;
  logic              bt_valid;

  logic              rsp_valid;
  logic [HOPS_W-1:0] rsp_hops;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_rd_en;

  logic              fwd_valid;
  logic [HOPS_W-1:0] fwd_hops;
  logic [DATA_W-1:0] fwd_data;
  logic              fwd_rd_en;

  modport slave (
    input  req_valid, req_hops, req_data, rsp_rd_en, fwd_rd_en,
    output bt_full, bt_empty, bt_prog_full, bt_valid,
    output rsp_valid, rsp_hops, rsp_data,
    output fwd_valid, fwd_hops, fwd_data
  );

  modport master (
    output req_valid, req_hops, req_data, rsp_rd_en, fwd_rd_en,
    input  bt_full, bt_empty, bt_prog_full, bt_valid,
    input  rsp_valid, rsp_hops, rsp_data,
    input  fwd_valid, fwd_hops, fwd_data
  );
endinterface

// File: rtl/engine_forward_data_receiver.sv
// ---------------------------------------------------------------------------
// engine_forward_data_receiver
//
// Purpose: ingress end of the engine forward-data path. Incoming packets are
// registered, buffered in an ingress FIFO and split on pop: hops==0 goes to
// the local engine port, hops>0 goes (hops unmodified) to the bypass port.
// The FIFO state is exported, registered, as the lane backtrack signal.
//
// Ports:
//   ap_clk             : clock
//   areset_n           : asynchronous active-low reset
//   bus (slave)        : request input, backtrack state, local and bypass
//                        output ports with their consumer readies
//   done_in            : upstream done
//   fifo_setup_signal  : high while initialising (no pops during this time)
//   overflow_error     : sticky, set when a packet is dropped on a full FIFO
//   done_out           : all traffic drained after done_in
//   stat_local_count   : local packets delivered (saturating)
//   stat_forward_count : bypass packets delivered (saturating)
//
// Optional build macro: ENGINE_FORWARD_RECEIVER_STATS_EN
//   defined   -> delivery counters are built
//   undefined -> both counters are tied to zero
// ---------------------------------------------------------------------------
module engine_forward_data_receiver #(
  parameter int ID_CU            = 0,
  parameter int ID_BUNDLE        = 0,
  parameter int ID_LANE          = 0,
  parameter int ID_ENGINE        = 0,
  parameter int FIFO_WRITE_DEPTH = 16,
  parameter int PROG_THRESH      = 8,
  parameter int SETUP_CYCLES     = 4,
  parameter int COUNTER_WIDTH    = 32,
  parameter int HOPS_W           = 8,
  parameter int DATA_W           = 32
) (
  input  logic                         ap_clk,
  input  logic                         areset_n,
  engine_forward_data_receiver_if.slave bus,
  input  logic                         done_in,
  output logic                         fifo_setup_signal,
  output logic                         overflow_error,
  output logic                         done_out,
  output logic [COUNTER_WIDTH-1:0]     stat_local_count,
  output logic [COUNTER_WIDTH-1:0]     stat_forward_count
);

  localparam int AW = $clog2(FIFO_WRITE_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(SETUP_CYCLES + 1);
  localparam int PW = HOPS_W + DATA_W;

  // The ID tags only label the instance; they are range-checked here.
  if (ID_CU < 0 || ID_BUNDLE < 0 || ID_LANE < 0 || ID_ENGINE < 0) begin : g_bad_id
    $error("engine_forward_data_receiver: ID parameters must be non-negative");
  end
  if (FIFO_WRITE_DEPTH < 8 || (FIFO_WRITE_DEPTH & (FIFO_WRITE_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("engine_forward_data_receiver: FIFO_WRITE_DEPTH must be a power of 2 >= 8");
  end

  typedef enum logic [1:0] {ST_SETUP, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t           state_reg, state_next;
  logic [SW-1:0]    setup_cnt_reg;

  logic             in_valid_reg;
  logic [PW-1:0]    in_pkt_reg;

  logic [PW-1:0]    fifo_mem [FIFO_WRITE_DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             fifo_full, fifo_empty, fifo_prog_full;
  logic             push, pop;
  logic [PW-1:0]    head_pkt;
  logic             head_sel;       // 0 = local port, 1 = bypass port

  logic             bt_full_reg, bt_empty_reg, bt_prog_full_reg, bt_valid_reg;
  logic             overflow_reg;

  // Output stage, index 0 = local, index 1 = bypass.
  logic [1:0]       out_valid_reg;
  logic [PW-1:0]    out_pkt_reg [2];
  logic [1:0]       port_rd_en;
  logic [1:0]       port_free;

  assign port_rd_en     = {bus.fwd_rd_en, bus.rsp_rd_en};

  assign fifo_full      = (count_reg == CW'(FIFO_WRITE_DEPTH));
  assign fifo_empty     = (count_reg == '0);
  assign fifo_prog_full = (count_reg >= CW'(PROG_THRESH));

  // Head is read combinationally so the pop decision and the output
  // register load happen on the same edge (3-cycle minimum latency).
  assign head_pkt = fifo_mem[rd_ptr_reg];
  assign head_sel = (head_pkt[PW-1 -: HOPS_W] != '0);

  // A full FIFO refuses the push even if it pops on the same edge.
  assign push = in_valid_reg && !fifo_full;
  // Strict head-of-line: only the head's target port is considered.
  assign pop  = !fifo_empty && (state_reg != ST_SETUP) && port_free[head_sel];

  // ---------------------------------------------------------------- input
  always_ff @(posedge ap_clk or negedge areset_n) begin
    if (!areset_n) begin
      in_valid_reg <= 1'b0;
      in_pkt_reg   <= '0;
    end else begin
      in_valid_reg <= bus.req_valid;
      in_pkt_reg   <= {bus.req_hops, bus.req_data};
    end
  end

  // ----------------------------------------------------------------- FIFO
  always_ff @(posedge ap_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= in_pkt_reg;
    end
  end

  always_ff @(posedge ap_clk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop);
      if (in_valid_reg && fifo_full) overflow_reg <= 1'b1;
    end
  end

  assign overflow_error = overflow_reg;

  // ------------------------------------------------------------ backtrack
  always_ff @(posedge ap_clk or negedge areset_n) begin
    if (!areset_n) begin
      bt_full_reg      <= 1'b0;
      bt_empty_reg     <= 1'b1;
      bt_prog_full_reg <= 1'b0;
      bt_valid_reg     <= 1'b0;
    end else begin
      bt_full_reg      <= fifo_full;
      bt_empty_reg     <= fifo_empty;
      bt_prog_full_reg <= fifo_prog_full;
      bt_valid_reg     <= !fifo_empty;
    end
  end

  assign bus.bt_full      = bt_full_reg;
  assign bus.bt_empty     = bt_empty_reg;
  assign bus.bt_prog_full = bt_prog_full_reg;
  assign bus.bt_valid     = bt_valid_reg;

  // --------------------------------------------------------- output stage
  for (genvar gi = 0; gi < 2; gi++) begin : g_out
    // Free when empty, or when its consumer takes the current word this edge.
    assign port_free[gi] = !out_valid_reg[gi] || port_rd_en[gi];

    always_ff @(posedge ap_clk or negedge areset_n) begin
      if (!areset_n) begin
        out_valid_reg[gi] <= 1'b0;
        out_pkt_reg[gi]   <= '0;
      end else if (pop && (head_sel == 1'(gi))) begin
        out_valid_reg[gi] <= 1'b1;
        out_pkt_reg[gi]   <= head_pkt;
      end else if (port_rd_en[gi]) begin
        out_valid_reg[gi] <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid = out_valid_reg[0];
  assign bus.rsp_hops  = out_pkt_reg[0][PW-1 -: HOPS_W];
  assign bus.rsp_data  = out_pkt_reg[0][DATA_W-1:0];
  assign bus.fwd_valid = out_valid_reg[1];
  assign bus.fwd_hops  = out_pkt_reg[1][PW-1 -: HOPS_W];
  assign bus.fwd_data  = out_pkt_reg[1][DATA_W-1:0];

  // ------------------------------------------------------------ statistics
`ifdef ENGINE_FORWARD_RECEIVER_STATS_EN
  logic [COUNTER_WIDTH-1:0] stat_cnt_reg [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_stat
    always_ff @(posedge ap_clk or negedge areset_n) begin
      if (!areset_n) begin
        stat_cnt_reg[gi] <= '0;
      end else if (out_valid_reg[gi] && port_rd_en[gi] && (stat_cnt_reg[gi] != '1)) begin
        stat_cnt_reg[gi] <= stat_cnt_reg[gi] + COUNTER_WIDTH'(1);
      end
    end
  end

  assign stat_local_count   = stat_cnt_reg[0];
  assign stat_forward_count = stat_cnt_reg[1];
`else
  assign stat_local_count   = '0;
  assign stat_forward_count = '0;
`endif

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge ap_clk or negedge areset_n) begin
    if (!areset_n) begin
      state_reg     <= ST_SETUP;
      setup_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_SETUP) setup_cnt_reg <= setup_cnt_reg + SW'(1);
    end
  end

  always_comb begin
    state_next        = state_reg;
    fifo_setup_signal = 1'b0;
    done_out          = 1'b0;
    unique case (state_reg)
      ST_SETUP: begin
        fifo_setup_signal = 1'b1;
        if (setup_cnt_reg == SW'(SETUP_CYCLES - 1)) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (done_in) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Late pushes keep us here until they have also left.
        if (fifo_empty && (out_valid_reg == 2'b00) && !in_valid_reg) state_next = ST_DONE;
      end
      ST_DONE: begin
        done_out = 1'b1;
        if (!done_in) state_next = ST_RUN;
      end
      default: state_next = ST_SETUP;
    endcase
  end

endmodule

// File: tb/tb_engine_forward_data_receiver.sv
module tb_engine_forward_data_receiver;

`ifdef ENGINE_FORWARD_RECEIVER_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic        ap_clk = 1'b0;
  logic        areset_n;
  logic        done_in;
  logic        fifo_setup_signal;
  logic        overflow_error;
  logic        done_out;
  logic [31:0] stat_local_count;
  logic [31:0] stat_forward_count;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [31:0] local_q[$];
  logic [31:0] fwd_q[$];

  engine_forward_data_receiver_if #(.HOPS_W(8), .DATA_W(32)) bus ();

  engine_forward_data_receiver dut (
    .ap_clk             (ap_clk),
    .areset_n           (areset_n),
    .bus                (bus),
    .done_in            (done_in),
    .fifo_setup_signal  (fifo_setup_signal),
    .overflow_error     (overflow_error),
    .done_out           (done_out),
    .stat_local_count   (stat_local_count),
    .stat_forward_count (stat_forward_count)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic idle_inputs();
    bus.req_valid = 1'b0;
    bus.req_hops  = 8'd0;
    bus.req_data  = 32'd0;
    bus.rsp_rd_en = 1'b0;
    bus.fwd_rd_en = 1'b0;
    done_in       = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    areset_n = 1'b0;
    repeat (2) @(negedge ap_clk);
    areset_n = 1'b1;
  endtask

  task automatic wait_setup();
    repeat (5) @(negedge ap_clk);
  endtask

  // Records what will hand over on the next rising edge (outputs are stable
  // at the falling edge and the readies have just been driven).
  task automatic record_handshakes();
    if (bus.rsp_valid && bus.rsp_rd_en) begin
      local_q.push_back(bus.rsp_data);
      $display("txn local  data=%h hops=%0d", bus.rsp_data, bus.rsp_hops);
    end
    if (bus.fwd_valid && bus.fwd_rd_en) begin
      fwd_q.push_back(bus.fwd_data);
      $display("txn bypass data=%h hops=%0d", bus.fwd_data, bus.fwd_hops);
    end
  endtask

  // ------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    areset_n = 1'b0;
    @(negedge ap_clk);
    checks_total++;
    if (fifo_setup_signal !== 1'b1) $display("FAIL rst_setup: got %b expected 1", fifo_setup_signal);
    else checks_passed++;
    checks_total++;
    if (bus.bt_empty !== 1'b1) $display("FAIL rst_bt_empty: got %b expected 1", bus.bt_empty);
    else checks_passed++;
    checks_total++;
    if ({bus.bt_full, bus.bt_prog_full, bus.bt_valid} !== 3'b000)
      $display("FAIL rst_bt_other: got %b expected 000", {bus.bt_full, bus.bt_prog_full, bus.bt_valid});
    else checks_passed++;
    checks_total++;
    if ({bus.rsp_valid, bus.fwd_valid, done_out, overflow_error} !== 4'b0000)
      $display("FAIL rst_outputs: got %b expected 0000", {bus.rsp_valid, bus.fwd_valid, done_out, overflow_error});
    else checks_passed++;
    checks_total++;
    if ({stat_local_count, stat_forward_count} !== 64'd0)
      $display("FAIL rst_stats: got %0d/%0d expected 0/0", stat_local_count, stat_forward_count);
    else checks_passed++;

    areset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks_total++;
      if (fifo_setup_signal !== (i < 4))
        $display("FAIL setup_seq[%0d]: got %b expected %b", i, fifo_setup_signal, (i < 4));
      else checks_passed++;
      @(negedge ap_clk);
    end
    checks_total++;
    if ({bus.bt_empty, bus.rsp_valid, bus.fwd_valid} !== 3'b100)
      $display("FAIL idle_after_setup: got %b expected 100", {bus.bt_empty, bus.rsp_valid, bus.fwd_valid});
    else checks_passed++;
  endtask

  // ------------------------------------------------------------------------
  task automatic test_local();
    do_reset();
    wait_setup();
    bus.rsp_rd_en = 1'b1;
    bus.fwd_rd_en = 1'b1;
    for (int c = 0; c < 9; c++) begin
      logic exp_v;
      exp_v = (c >= 3 && c <= 5);
      checks_total++;
      if (bus.rsp_valid !== exp_v) $display("FAIL local_valid[c%0d]: got %b expected %b", c, bus.rsp_valid, exp_v);
      else checks_passed++;
      if (exp_v) begin
        checks_total++;
        if (bus.rsp_data !== 32'(32'hA1 + c - 3) || bus.rsp_hops !== 8'd0)
          $display("FAIL local_data[c%0d]: got %h/%0d expected %h/0", c, bus.rsp_data, bus.rsp_hops, 32'(32'hA1 + c - 3));
        else checks_passed++;
      end
      checks_total++;
      if (bus.fwd_valid !== 1'b0) $display("FAIL local_fwd_idle[c%0d]: got %b expected 0", c, bus.fwd_valid);
      else checks_passed++;
      bus.req_valid = (c < 3);
      bus.req_hops  = 8'd0;
      bus.req_data  = 32'(32'hA1 + c);
      @(negedge ap_clk);
    end
    checks_total++;
    if (stat_local_count !== (STATS_ON ? 32'd3 : 32'd0))
      $display("FAIL local_stat: got %0d expected %0d", stat_local_count, (STATS_ON ? 3 : 0));
    else checks_passed++;
    checks_total++;
    if (stat_forward_count !== 32'd0) $display("FAIL local_fwd_stat: got %0d expected 0", stat_forward_count);
    else checks_passed++;
  endtask

  // ------------------------------------------------------------------------
  task automatic test_head_of_line();
    logic [7:0]  hops_tab [6];
    logic [31:0] exp_local [3];
    logic [31:0] exp_fwd [3];
    hops_tab  = '{8'd0, 8'd2, 8'd0, 8'd2, 8'd0, 8'd2};
    exp_local = '{32'h10, 32'h12, 32'h14};
    exp_fwd   = '{32'h11, 32'h13, 32'h15};
    local_q.delete();
    fwd_q.delete();
    do_reset();
    wait_setup();
    bus.rsp_rd_en = 1'b1;
    for (int c = 0; c < 22; c++) begin
      if (c == 10) begin
        // p3 (bypass) heads the FIFO behind the stalled p1, so p4 waits.
        checks_total++;
        if (local_q.size() !== 2) $display("FAIL hol_local_count: got %0d expected 2", local_q.size());
        else checks_passed++;
        checks_total++;
        if (bus.rsp_valid !== 1'b0) $display("FAIL hol_local_blocked: got %b expected 0", bus.rsp_valid);
        else checks_passed++;
        checks_total++;
        if (bus.fwd_valid !== 1'b1 || bus.fwd_data !== 32'h11)
          $display("FAIL hol_fwd_hold: got %b/%h expected 1/00000011", bus.fwd_valid, bus.fwd_data);
        else checks_passed++;
        checks_total++;
        if (bus.bt_empty !== 1'b0 || bus.bt_prog_full !== 1'b0)
          $display("FAIL hol_backtrack: got empty=%b prog=%b expected 0/0", bus.bt_empty, bus.bt_prog_full);
        else checks_passed++;
      end
      bus.req_valid = (c < 6);
      bus.req_hops  = (c < 6) ? hops_tab[c] : 8'd0;
      bus.req_data  = 32'(32'h10 + c);
      bus.fwd_rd_en = (c >= 10);
      if (bus.fwd_valid && bus.fwd_rd_en) begin
        checks_total++;
        if (bus.fwd_hops !== 8'd2) $display("FAIL hol_fwd_hops: got %0d expected 2", bus.fwd_hops);
        else checks_passed++;
      end
      record_handshakes();
      @(negedge ap_clk);
    end
    checks_total++;
    if (local_q.size() !== 3) $display("FAIL hol_local_total: got %0d expected 3", local_q.size());
    else checks_passed++;
    checks_total++;
    if (fwd_q.size() !== 3) $display("FAIL hol_fwd_total: got %0d expected 3", fwd_q.size());
    else checks_passed++;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] got_l, got_f;
      got_l = (i < local_q.size()) ? local_q[i] : 32'hxxxx_xxxx;
      got_f = (i < fwd_q.size())   ? fwd_q[i]   : 32'hxxxx_xxxx;
      checks_total++;
      if (got_l !== exp_local[i]) $display("FAIL hol_local_order[%0d]: got %h expected %h", i, got_l, exp_local[i]);
      else checks_passed++;
      checks_total++;
      if (got_f !== exp_fwd[i]) $display("FAIL hol_fwd_order[%0d]: got %h expected %h", i, got_f, exp_fwd[i]);
      else checks_passed++;
    end
  endtask

  // ------------------------------------------------------------------------
  // One packet parks in the local output register, so the FIFO fills after
  // 17 packets and the 18th is the one that gets dropped.
  task automatic test_overflow();
    local_q.delete();
    fwd_q.delete();
    do_reset();
    wait_setup();
    for (int c = 0; c < 45; c++) begin
      if (c == 10 || c == 11) begin
        checks_total++;
        if (bus.bt_prog_full !== (c == 11))
          $display("FAIL ovf_prog_full[c%0d]: got %b expected %b", c, bus.bt_prog_full, (c == 11));
        else checks_passed++;
      end
      if (c == 18 || c == 19) begin
        checks_total++;
        if (overflow_error !== (c == 19))
          $display("FAIL ovf_flag[c%0d]: got %b expected %b", c, overflow_error, (c == 19));
        else checks_passed++;
        checks_total++;
        if (bus.bt_full !== (c == 19))
          $display("FAIL ovf_bt_full[c%0d]: got %b expected %b", c, bus.bt_full, (c == 19));
        else checks_passed++;
      end
      if (c >= 20 && c <= 36) begin
        checks_total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'(c - 20))
          $display("FAIL ovf_stream[c%0d]: got %b/%h expected 1/%h", c, bus.rsp_valid, bus.rsp_data, 32'(c - 20));
        else checks_passed++;
      end
      bus.req_valid = (c < 18);
      bus.req_hops  = 8'd0;
      bus.req_data  = 32'(c);
      bus.rsp_rd_en = (c >= 20);
      record_handshakes();
      @(negedge ap_clk);
    end
    checks_total++;
    if (local_q.size() !== 17) $display("FAIL ovf_delivered: got %0d expected 17", local_q.size());
    else checks_passed++;
    checks_total++;
    if (overflow_error !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", overflow_error);
    else checks_passed++;
    checks_total++;
    if (bus.bt_empty !== 1'b1 || bus.bt_full !== 1'b0)
      $display("FAIL ovf_drained: got empty=%b full=%b expected 1/0", bus.bt_empty, bus.bt_full);
    else checks_passed++;
    checks_total++;
    if (stat_local_count !== (STATS_ON ? 32'd17 : 32'd0))
      $display("FAIL ovf_stat: got %0d expected %0d", stat_local_count, (STATS_ON ? 17 : 0));
    else checks_passed++;
  endtask

  // ------------------------------------------------------------------------
  task automatic test_done();
    local_q.delete();
    fwd_q.delete();
    do_reset();
    wait_setup();
    for (int c = 0; c < 15; c++) begin
      logic exp_done;
      exp_done = (c >= 9 && c <= 12);
      checks_total++;
      if (done_out !== exp_done) $display("FAIL done_out[c%0d]: got %b expected %b", c, done_out, exp_done);
      else checks_passed++;
      bus.req_valid = (c < 2);
      bus.req_hops  = 8'd0;
      bus.req_data  = 32'(32'h30 + c);
      done_in       = (c >= 2 && c < 12);
      bus.rsp_rd_en = (c >= 6);
      record_handshakes();
      @(negedge ap_clk);
    end
    checks_total++;
    if (local_q.size() !== 2) $display("FAIL done_delivered: got %0d expected 2", local_q.size());
    else checks_passed++;
  endtask

  // ------------------------------------------------------------------------
  task automatic test_reset_mid();
    logic [7:0] hops_tab [6];
    hops_tab = '{8'd0, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2};
    local_q.delete();
    fwd_q.delete();
    do_reset();
    wait_setup();
    bus.rsp_rd_en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.req_valid = (c < 6);
      bus.req_hops  = (c < 6) ? hops_tab[c] : 8'd0;
      bus.req_data  = 32'(32'h50 + c);
      record_handshakes();
      @(negedge ap_clk);
    end
    // One bypass packet in the output register, four in the FIFO.
    checks_total++;
    if (bus.fwd_valid !== 1'b1 || bus.bt_empty !== 1'b0)
      $display("FAIL mid_buffered: got fwd_valid=%b empty=%b expected 1/0", bus.fwd_valid, bus.bt_empty);
    else checks_passed++;
    checks_total++;
    if (stat_local_count !== (STATS_ON ? 32'd1 : 32'd0))
      $display("FAIL mid_stat_before: got %0d expected %0d", stat_local_count, (STATS_ON ? 1 : 0));
    else checks_passed++;

    #2;
    areset_n = 1'b0;
    #1;
    checks_total++;
    if ({bus.rsp_valid, bus.fwd_valid, bus.bt_full, bus.bt_prog_full, bus.bt_valid} !== 5'b00000)
      $display("FAIL mid_async_outputs: got %b expected 00000",
               {bus.rsp_valid, bus.fwd_valid, bus.bt_full, bus.bt_prog_full, bus.bt_valid});
    else checks_passed++;
    checks_total++;
    if ({bus.bt_empty, fifo_setup_signal, done_out, overflow_error} !== 4'b1100)
      $display("FAIL mid_async_flags: got %b expected 1100", {bus.bt_empty, fifo_setup_signal, done_out, overflow_error});
    else checks_passed++;
    checks_total++;
    if ({stat_local_count, stat_forward_count} !== 64'd0)
      $display("FAIL mid_async_stats: got %0d/%0d expected 0/0", stat_local_count, stat_forward_count);
    else checks_passed++;

    idle_inputs();
    @(negedge ap_clk);
    areset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (i < 5) begin
        checks_total++;
        if (fifo_setup_signal !== (i < 4))
          $display("FAIL mid_setup_seq[%0d]: got %b expected %b", i, fifo_setup_signal, (i < 4));
        else checks_passed++;
      end
      checks_total++;
      if ({bus.bt_empty, bus.rsp_valid, bus.fwd_valid} !== 3'b100)
        $display("FAIL mid_post_empty[%0d]: got %b expected 100", i, {bus.bt_empty, bus.rsp_valid, bus.fwd_valid});
      else checks_passed++;
      @(negedge ap_clk);
    end
  endtask

  // ------------------------------------------------------------------------
  initial begin
    areset_n = 1'b0;
    idle_inputs();
    test_reset();
    test_local();
    test_head_of_line();
    test_overflow();
    test_done();
    test_reset_mid();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", checks_passed, checks_total);
    $fatal(1, "watchdog");
  end

endmodule
